// File: rtl/skinny_pkg.sv
// Shared definitions for the SKINNY-128-384+ round sequencer: round count,
// FSM encoding and the 6-bit round-constant LFSR step.
package skinny_pkg;

  localparam int SKINNY_ROUNDS = 40;

  function automatic int calc_cycles(input int numrnd);
    return SKINNY_ROUNDS / numrnd;
  endfunction

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_RUN  = 2'd1;
  localparam logic [1:0] FSM_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = FSM_IDLE,
    S_RUN  = FSM_RUN,
    S_DONE = FSM_DONE
  } fsm_t;

  function automatic logic [5:0] rc_step(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/skinny_rc_gen.sv
// Combinational round-constant generator: unrolls NUMRND LFSR steps from the
// current constant register and also returns the last value for reloading.
module skinny_rc_gen
  import skinny_pkg::*;
#(
  parameter int NUMRND = 2
) (
  input  logic [5:0]          i_rc,
  output logic [6*NUMRND-1:0] o_const,
  output logic [5:0]          o_last
);

  logic [5:0] w_rc;

  always_comb begin
    w_rc    = i_rc;
    o_const = '0;
    for (int i = 0; i < NUMRND; i++) begin
      w_rc               = rc_step(w_rc);
      o_const[6*i +: 6]  = w_rc;
    end
    o_last = w_rc;
  end

endmodule

// File: rtl/skinny_rnd_ctrl.sv
// Iterative sequencer driving the unrolled SKINNY-128-384+ datapath for 40 rounds.
// Optional macro SKINNY_RND_CTRL_BACK2BACK_EN lets DONE accept the next block directly.
module skinny_rnd_ctrl
  import skinny_pkg::*;
#(
  parameter int NUMRND  = 2,
  parameter int FULLCNT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [127:0]              state_i,
  input  logic [127:0]              tweak_i,
  input  logic [127:0]              key_i,
  input  logic [64+64*FULLCNT-1:0]  cnt_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [127:0]              state_o,
  output logic [127:0]              rnd_state_o,
  output logic [127:0]              rnd_tweak_o,
  output logic [127:0]              rnd_key_o,
  output logic [64+64*FULLCNT-1:0]  rnd_cnt_o,
  output logic [6*NUMRND-1:0]       rnd_const_o,
  input  logic [127:0]              nxt_state_i,
  input  logic [127:0]              nxt_tweak_i,
  input  logic [127:0]              nxt_key_i,
  input  logic [64+64*FULLCNT-1:0]  nxt_cnt_i
);

  localparam int CYCLES = calc_cycles(NUMRND);
  localparam int CYC_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int CNT_W  = 64 + 64 * FULLCNT;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES - 1);

  fsm_t              r_fsm;
  fsm_t              w_fsm_nxt;
  logic              w_accept;
  logic              w_step;
  logic [127:0]      r_state;
  logic [127:0]      r_tweak;
  logic [127:0]      r_key;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        r_rc;
  logic [CYC_W-1:0]  r_cyc;
  logic [5:0]        w_rc_last;

  skinny_rc_gen #(.NUMRND(NUMRND)) u_rc_gen (
    .i_rc    (r_rc),
    .o_const (rnd_const_o),
    .o_last  (w_rc_last)
  );

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cyc == CYC_LAST) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
`ifdef SKINNY_RND_CTRL_BACK2BACK_EN
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) begin
            w_accept  = 1'b1;
            w_fsm_nxt = S_RUN;
          end else begin
            w_fsm_nxt = S_IDLE;
          end
        end
`else
        if (out_ready_i) w_fsm_nxt = S_IDLE;
`endif
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // cyc saturates on the final round so it can never wrap for power-of-two CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_tweak <= '0;
      r_key   <= '0;
      r_cnt   <= '0;
      r_rc    <= '0;
      r_cyc   <= '0;
    end else if (w_accept) begin
      r_state <= state_i;
      r_tweak <= tweak_i;
      r_key   <= key_i;
      r_cnt   <= cnt_i;
      r_rc    <= '0;
      r_cyc   <= '0;
    end else if (w_step) begin
      r_state <= nxt_state_i;
      r_tweak <= nxt_tweak_i;
      r_key   <= nxt_key_i;
      r_cnt   <= nxt_cnt_i;
      r_rc    <= w_rc_last;
      if (r_cyc != CYC_LAST) r_cyc <= r_cyc + CYC_W'(1);
    end
  end

  assign state_o     = r_state;
  assign rnd_state_o = r_state;
  assign rnd_tweak_o = r_tweak;
  assign rnd_key_o   = r_key;
  assign rnd_cnt_o   = r_cnt;

endmodule

// File: doc/skinny_rnd_ctrl.md
# skinny_rnd_ctrl

Iterative sequencer for the unrolled SKINNY-128-384+ round datapath (`skinny_rnd`) used by the Romulus core. It accepts one block (state, TK1 counter, TK2 tweak, TK3 key) over a valid/ready handshake. It owns the state and tweakey registers and drives them through the datapath for 40 rounds, NUMRND rounds per clock. It generates the packed 6-bit round constants and presents the ciphertext on a valid/ready output handshake.

## Interface
- NUMRND, 2, rounds per cycle; must divide 40 (1, 2, 4, 5, 8, 10); must match the datapath instance.
- FULLCNT, 1, 1 gives a 128-bit TK1 counter; 0 gives 64 bits; must match the datapath.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  block offered.
- in_ready_o  out  1  controller can accept.
- state_i, tweak_i, key_i  in  128 each  plaintext, TK2, TK3.
- cnt_i  in  64+64*FULLCNT  TK1 counter.
- out_valid_o  out  1  ciphertext valid.
- out_ready_i  in  1  consumer accepts.
- state_o  out  128  ciphertext; the state register.
- rnd_state_o, rnd_tweak_o, rnd_key_o  out  128  to datapath roundstate/roundtweak/roundkey.
- rnd_cnt_o  out  64+64*FULLCNT  to datapath roundcnt.
- rnd_const_o  out  6*NUMRND  to datapath constant; slice [6i+5:6i] is the constant for the i-th round of the cycle.
- nxt_state_i, nxt_tweak_i, nxt_key_i  in  128  from datapath.
- nxt_cnt_i  in  64+64*FULLCNT  from datapath.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready_o=1. On in_valid_i, load the four data registers from the inputs, clear rc and cyc, and go to RUN.
- RUN: every cycle, register nxt_* into the data registers, load rc with the last constant of the cycle, and increment cyc. When cyc==CYCLES-1 (CYCLES=40/NUMRND), go to DONE.
- DONE: out_valid_o=1 and state_o is stable. On out_ready_i, go to IDLE.
- in_ready_o=0 in RUN and DONE. The exception is under the macro (see Configuration).
- rnd_*_o are wired directly from the data registers.
- Round-constant LFSR, 6-bit: step(x) = {x[4:0], x[5]^x[4]^1}.
  - rnd_const_o slice i = step^(i+1)(rc).
  - Sequence from rc=0: 01,03,07,0F,1F,3E,3D,3B,…
- cyc width is clog2(CYCLES) and it never wraps; it is cleared on every accept.
- in_valid_i is ignored in RUN and DONE. The input data need only be valid in the accepting cycle.
- rst in any state: next cycle is IDLE, all registers are 0, and any in-flight block is discarded with no output.

## Timing
- Reset values: in_ready_o=1 (IDLE), out_valid_o=0, state_o=0, rnd_*_o=0, rnd_const_o=step-chain of 0 (slice0=01).
- Accept on edge E0. RUN spans edges E1..E_CYCLES. out_valid_o rises after edge E_CYCLES.
- Example latency at NUMRND=2: accept to out_valid_o is 20 cycles.
- Output is held indefinitely under out_valid_o=1 & out_ready_i=0.
- Minimum throughput without the macro: CYCLES+2 cycles per block (accept, RUN×CYCLES, DONE handshake).

## Configuration
- SKINNY_RND_CTRL_BACK2BACK_EN defined: in DONE, in_ready_o = out_ready_i.
  - When out_valid_o & out_ready_i & in_valid_i occur in the same cycle, the new block is loaded and the FSM goes straight to RUN.
  - Throughput is then CYCLES+1 cycles per block.
- Undefined: DONE always returns to IDLE, and in_ready_o=0 in DONE.

## Structure
- Package skinny_pkg:
  - SKINNY_ROUNDS=40
  - CYCLES derivation
  - FSM state encoding (2-bit localparams)
  - LFSR step function
- Sub-module skinny_rc_gen: combinational, unrolls NUMRND LFSR steps from rc, outputs the packed 6*NUMRND bus and the last value.
- The datapath is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle: in_ready_o=1, out_valid_o=0, rnd_const_o slice0=01; at NUMRND=2, rnd_const_o=6'h03,6'h01 packed.
- Constant sequence: accept a block and log rnd_const_o per RUN cycle. At NUMRND=2, cycle 0 gives {03,01} and cycle 1 gives {0F,07}. All 40 values must match the LFSR model.
- Full encryption at NUMRND=1,2,4 with the datapath attached: state_o must match the SKINNY-128-384+ golden model. out_valid_o must rise exactly CYCLES cycles after accept.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE. state_o must stay stable and in_valid_i must be ignored (in_ready_o=0 without the macro).
- Back-to-back with the macro: present in_valid_i and out_ready_i together in DONE. The new block must load, and the next out_valid_o must come CYCLES+1 cycles after the previous one.
- Reset mid-RUN: assert rst at cyc=5. The next cycle must be IDLE with out_valid_o=0, and no ciphertext is emitted for the aborted block.
